// File: rtl/cpu_final_project_key_pio_if.sv
// Avalon-MM slave bus for the key PIO: word address, select, write strobe and data paths.
`timescale 1ns/1ps
interface cpu_final_project_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/cpu_final_project_key_pio.sv
// Debounced key PIO: synchronizes board keys, filters bounce, captures edges and raises
// a maskable level interrupt. Registers: 0 = debounced keys, 2 = irq mask, 3 = edge capture (W1C).
`timescale 1ns/1ps
module cpu_final_project_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  cpu_final_project_key_pio_if.slave      bus,
  input  logic [WIDTH-1:0]                in_port,
  output logic                            irq
);

  localparam int CNT_W    = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LAST_INT = (DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic             wr_en;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_data;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      db_q           <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      db_q           <= db_d;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Per-bit debounce: a new level must persist for DEBOUNCE_CYCLES clocks before db follows it.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        db_d[i] = sync2_q[i];
      end else if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_hit = ~db_q & db_d;
      1:       edge_hit = db_q & ~db_d;
      default: edge_hit = db_q ^ db_d;
    endcase
  end

  // A capture arriving on the same edge as a software clear wins, so no edge is lost.
  always_comb begin
    clr_mask   = '0;
    irq_mask_d = irq_mask_q;
    if (wr_en && bus.address == 2'd3) clr_mask   = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == 2'd2) irq_mask_d = bus.writedata[WIDTH-1:0];
    edge_capture_d = (edge_capture_q & ~clr_mask) | edge_hit;
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      2'd0:    rd_data[WIDTH-1:0] = db_q;
      2'd2:    rd_data[WIDTH-1:0] = irq_mask_q;
      2'd3:    rd_data[WIDTH-1:0] = edge_capture_q;
      default: rd_data = '0;
    endcase
  end

  assign bus.readdata = rd_data;
  assign irq          = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_cpu_final_project_key_pio.sv
// Directed bench for the key PIO: one falling-edge instance and one any-edge instance share stimulus.
`timescale 1ns/1ps
module tb_cpu_final_project_key_pio;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq1, irq2;
  int         n_compared;
  int         n_mismatched;
  logic [31:0] rd1, rd2;

  cpu_final_project_key_pio_if bus1 ();
  cpu_final_project_key_pio_if bus2 ();

  cpu_final_project_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .in_port(in_port), .irq(irq1)
  );

  cpu_final_project_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port), .irq(irq2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_reg(input logic [1:0] a);
    bus1.address = a;
    bus2.address = a;
    #1;
    rd1 = bus1.readdata;
    rd2 = bus2.readdata;
  endtask

  // One bus write to both instances, issued on a negedge so it lands on the next rising edge.
  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    bus1.address = a;  bus1.writedata = d;  bus1.chipselect = 1'b1;  bus1.write_n = 1'b0;
    bus2.address = a;  bus2.writedata = d;  bus2.chipselect = 1'b1;  bus2.write_n = 1'b0;
    @(negedge clk);
    bus1.chipselect = 1'b0;  bus1.write_n = 1'b1;
    bus2.chipselect = 1'b0;  bus2.write_n = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset_n      = 1'b0;
    in_port      = 4'hF;
    bus1.address = 2'd0;  bus1.chipselect = 1'b0;  bus1.write_n = 1'b1;  bus1.writedata = '0;
    bus2.address = 2'd0;  bus2.chipselect = 1'b0;  bus2.write_n = 1'b1;  bus2.writedata = '0;

    tick(2);
    read_reg(2'd0);  checkOutput("reset_db", rd1, 32'h0);
    read_reg(2'd3);  checkOutput("reset_ec", rd1, 32'h0);
    checkOutput("reset_irq", {31'b0, irq1}, 32'h0);

    // Reset release with keys idle high: db follows six edges later
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      read_reg(2'd0);
      checkOutput($sformatf("release_db_e%0d", e), rd1, (e >= 6) ? 32'hF : 32'h0);
    end
    read_reg(2'd3);  checkOutput("release_ec", rd1, 32'h0);
    checkOutput("release_irq", {31'b0, irq1}, 32'h0);

    // Debounced press of key 0 with its interrupt enabled
    applyStimulus(2'd2, 32'h1);
    in_port = 4'hE;
    tick(5);
    read_reg(2'd0);  checkOutput("press_db_e5", rd1, 32'hF);
    read_reg(2'd3);  checkOutput("press_ec_e5", rd1, 32'h0);
    tick(1);
    read_reg(2'd0);  checkOutput("press_db_e6", rd1, 32'hE);
    read_reg(2'd3);  checkOutput("press_ec_e6", rd1, 32'h1);
    checkOutput("press_irq", {31'b0, irq1}, 32'h1);
    applyStimulus(2'd3, 32'h1);
    checkOutput("w1c_irq", {31'b0, irq1}, 32'h0);
    read_reg(2'd3);  checkOutput("w1c_ec", rd1, 32'h0);
    in_port = 4'hF;
    tick(8);
    read_reg(2'd0);  checkOutput("release_key0_db", rd1, 32'hF);
    read_reg(2'd3);  checkOutput("release_key0_ec", rd1, 32'h0);

    // Bounce shorter than the debounce window is rejected
    in_port = 4'hE;  tick(3);
    in_port = 4'hF;  tick(1);
    in_port = 4'hE;  tick(3);
    in_port = 4'hF;  tick(8);
    read_reg(2'd0);  checkOutput("bounce_db", rd1, 32'hF);
    read_reg(2'd3);  checkOutput("bounce_ec", rd1, 32'h0);
    checkOutput("bounce_irq", {31'b0, irq1}, 32'h0);

    // Clear collides with a capture on the same edge: the capture survives
    in_port = 4'hD;
    tick(5);
    applyStimulus(2'd3, 32'h2);
    read_reg(2'd3);  checkOutput("collide_ec", rd1, 32'h2);
    checkOutput("collide_irq", {31'b0, irq1}, 32'h0);
    applyStimulus(2'd3, 32'h2);
    read_reg(2'd3);  checkOutput("collide_clear_ec", rd1, 32'h0);
    in_port = 4'hF;
    tick(8);

    // Masked capture, late unmask, readback and ignored writes
    applyStimulus(2'd2, 32'h0);
    in_port = 4'h7;
    tick(8);
    read_reg(2'd3);  checkOutput("masked_ec", rd1, 32'h8);
    checkOutput("masked_irq", {31'b0, irq1}, 32'h0);
    applyStimulus(2'd2, 32'h8);
    checkOutput("unmask_irq", {31'b0, irq1}, 32'h1);
    read_reg(2'd2);  checkOutput("mask_readback", rd1, 32'h8);
    read_reg(2'd1);  checkOutput("addr1_zero", rd1, 32'h0);
    applyStimulus(2'd0, 32'hFFFF_FFFF);
    applyStimulus(2'd1, 32'hFFFF_FFFF);
    read_reg(2'd0);  checkOutput("ro_db", rd1, 32'h7);
    read_reg(2'd2);  checkOutput("ro_mask", rd1, 32'h8);
    read_reg(2'd3);  checkOutput("ro_ec", rd1, 32'h8);
    applyStimulus(2'd3, 32'h8);
    in_port = 4'hF;
    tick(8);

    // Reset in the middle of a debounce count
    in_port = 4'hE;
    tick(4);
    reset_n = 1'b0;
    read_reg(2'd0);  checkOutput("midrst_db", rd1, 32'h0);
    read_reg(2'd2);  checkOutput("midrst_mask", rd1, 32'h0);
    read_reg(2'd3);  checkOutput("midrst_ec", rd1, 32'h0);
    checkOutput("midrst_irq", {31'b0, irq1}, 32'h0);
    tick(1);
    in_port = 4'hF;
    reset_n = 1'b1;
    tick(5);
    read_reg(2'd0);  checkOutput("midrst_db_e5", rd1, 32'h0);
    tick(1);
    read_reg(2'd0);  checkOutput("midrst_db_e6", rd1, 32'hF);
    read_reg(2'd3);
    checkOutput("midrst_ec_fall", rd1, 32'h0);
    checkOutput("midrst_ec_any", rd2, 32'hF);

    // Any-edge instance captures both the press and the release of key 2
    applyStimulus(2'd3, 32'hF);
    in_port = 4'hB;
    tick(6);
    read_reg(2'd3);
    checkOutput("any_press_ec", rd2, 32'h4);
    checkOutput("fall_press_ec", rd1, 32'h4);
    applyStimulus(2'd3, 32'h4);
    in_port = 4'hF;
    tick(6);
    read_reg(2'd3);
    checkOutput("any_release_ec", rd2, 32'h4);
    checkOutput("fall_release_ec", rd1, 32'h0);
    read_reg(2'd0);  checkOutput("any_release_db", rd2, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
